// File: rtl/calc_record_arbiter.sv
// calc_record_arbiter
// Merges fixed-width calculation records from NUM_PORTS requesters into a
// single-beat AXI-Stream. Each requester uses a 4-phase valid/ack handshake.
// A round-robin arbiter loads one record per cycle into a single output
// register. A new record can load on the same edge that the previous one
// is accepted. The block also tags each record with a one-hot source port
// and counts the records that were accepted downstream.

module calc_record_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 160,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            arb_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tstrb,
    output logic [7:0]                      m_tuser,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [CNT_WIDTH-1:0]            record_count
);

    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SUM_W  = PTR_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic {
        P_IDLE  = 1'b0,
        P_ACKED = 1'b1
    } port_state_e;

    port_state_e                 port_state_q [NUM_PORTS];
    logic [PTR_W-1:0]            rr_ptr_q;
    logic [PTR_W-1:0]            rr_ptr_d;
    logic [DATA_WIDTH-1:0]       m_tdata_q;
    logic [STRB_W-1:0]           m_tstrb_q;
    logic [7:0]                  m_tuser_q;
    logic [7:0]                  m_tuser_d;
    logic                        m_tvalid_q;
    logic [CNT_WIDTH-1:0]        record_count_q;

    logic [NUM_PORTS-1:0]        eligible;
    logic                        grant_found;
    logic [PTR_W-1:0]            grant_idx;
    logic [SUM_W-1:0]            search_pos;
    logic [NUM_PORTS-1:0]        grant_onehot;
    logic [DATA_WIDTH-1:0]       grant_data;
    logic                        accept;
    logic                        slot_free;
    logic                        do_grant;

    // A downstream accept frees the slot on the same edge. This lets a
    // new record load with no bubble.
    assign accept    = m_tvalid_q & m_tready;
    assign slot_free = ~m_tvalid_q | m_tready;
    assign do_grant  = arb_en & slot_free & grant_found;

    // A port may compete only while it requests and is not still holding an ack.
    always_comb begin
        // NOTE: every variable gets a default before any conditional logic, so no latch is inferred.
        eligible = '0;
        req_ack  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] && (port_state_q[i] == P_IDLE);
            req_ack[i]  = (port_state_q[i] == P_ACKED);
        end
    end

    // Pick the first eligible port, starting at rr_ptr and wrapping modulo NUM_PORTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_pos  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            search_pos = SUM_W'(rr_ptr_q) + SUM_W'(k);
            if (search_pos >= SUM_W'(NUM_PORTS)) begin
                search_pos = search_pos - SUM_W'(NUM_PORTS);
            end
            if (!grant_found && eligible[search_pos[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = search_pos[PTR_W-1:0];
            end
        end
    end

    // Decode the winner into its record slice, its one-hot tag and the next pointer.
    always_comb begin
        grant_data   = '0;
        grant_onehot = '0;
        m_tuser_d    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_onehot[i] = 1'b1;
            end
        end
        m_tuser_d[NUM_PORTS-1:0] = grant_onehot;
        if (grant_idx == PTR_W'(NUM_PORTS - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
        end
    end

    // Per-port handshake FSMs: ack on grant, release once the requester drops valid.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_state_q[i] <= P_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                case (port_state_q[i])
                    P_IDLE: begin
                        if (do_grant && grant_onehot[i]) begin
                            port_state_q[i] <= P_ACKED;
                        end
                    end
                    P_ACKED: begin
                        if (!req_valid[i]) begin
                            port_state_q[i] <= P_IDLE;
                        end
                    end
                    default: port_state_q[i] <= P_IDLE;
                endcase
            end
        end
    end

    // Output slot: load on grant, empty on accept without a grant, hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tdata_q  <= '0;
            m_tstrb_q  <= '0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else if (do_grant) begin
            m_tdata_q  <= grant_data;
            m_tstrb_q  <= '1;
            m_tuser_q  <= m_tuser_d;
            m_tvalid_q <= 1'b1;
        end else if (accept) begin
            m_tstrb_q  <= '0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the most recent winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (do_grant) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Count accepted records; the count wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            record_count_q <= '0;
        end else if (accept) begin
            record_count_q <= record_count_q + CNT_WIDTH'(1);
        end
    end

    assign m_tdata      = m_tdata_q;
    assign m_tstrb      = m_tstrb_q;
    assign m_tuser      = m_tuser_q;
    assign m_tvalid     = m_tvalid_q;
    assign m_tlast      = m_tvalid_q;
    assign record_count = record_count_q;

endmodule

// File: tb/tb_calc_record_arbiter.sv
// Testbench for calc_record_arbiter. The stimulus comes from 4-phase
// requester agents. A reference model sees only the bench's own inputs.
// For each grant it predicts, the model queues the expected record. A
// negedge monitor compares every output cycle against that queue and
// against the model's ack, valid and count state.

module tb_calc_record_arbiter;

    localparam int NP = 4;
    localparam int DW = 160;
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    user;
    } rec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    user;
        int            stamp;
    } log_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               arb_en = 1'b1;
    logic [NP*DW-1:0]   req_data = '0;
    logic [NP-1:0]      req_valid = '0;
    logic [NP-1:0]      req_ack;
    logic [DW-1:0]      m_tdata;
    logic [DW/8-1:0]    m_tstrb;
    logic [7:0]         m_tuser;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready = 1'b1;
    logic [CW-1:0]      record_count;

    calc_record_arbiter #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ack     (req_ack),
        .m_tdata     (m_tdata),
        .m_tstrb     (m_tstrb),
        .m_tuser     (m_tuser),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .record_count(record_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Requester agent controls
    int            ph       [NP];
    int            hold     [NP];
    int            hold_set [NP];
    logic [NP-1:0] force_req = '0;
    logic [DW-1:0] force_data [NP];
    bit            rand_en = 1'b0;

    // Reference model state
    logic [NP-1:0] m_ack   = '0;
    bit            m_valid = 1'b0;
    int            m_rr    = 0;
    logic [CW-1:0] m_cnt   = '0;
    rec_t          exp_q[$];
    log_t          log_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_record();
        logic [DW-1:0] r;
        r = '0;
        for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // One step of every requester agent, executed shortly after each rising edge.
    task automatic drive_step();
        logic [DW-1:0] d;
        for (int i = 0; i < NP; i++) begin
            case (ph[i])
                0: if (force_req[i] || (rand_en && $urandom_range(0, 3) == 0)) begin
                    d = force_req[i] ? force_data[i] : rand_record();
                    req_data[i*DW +: DW] = d;
                    req_valid[i] = 1'b1;
                    force_req[i] = 1'b0;
                    ph[i] = 1;
                end
                1: if (req_ack[i]) begin
                    hold[i] = (hold_set[i] >= 0) ? hold_set[i] : $urandom_range(0, 3);
                    if (hold[i] == 0) begin
                        req_valid[i] = 1'b0;
                        ph[i] = 3;
                    end else begin
                        ph[i] = 2;
                    end
                end
                2: begin
                    hold[i]--;
                    if (hold[i] <= 0) begin
                        req_valid[i] = 1'b0;
                        ph[i] = 3;
                    end
                end
                default: if (!req_ack[i]) ph[i] = 0;
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            ph[i] = 0;
            hold[i] = 0;
            hold_set[i] = 0;
            force_data[i] = '0;
        end
        forever begin
            @(posedge clk);
            #2;
            drive_step();
        end
    end

    // Reference model: the specification's arbitration rules, driven by bench inputs only.
    always @(posedge clk or posedge reset) begin
        bit            acc;
        bit            free;
        int            g;
        int            idx;
        logic [NP-1:0] nxt_ack;
        rec_t          r;
        if (reset) begin
            m_ack   = '0;
            m_valid = 1'b0;
            m_rr    = 0;
            m_cnt   = '0;
            exp_q.delete();
        end else begin
            acc  = m_valid && m_tready;
            free = !m_valid || acc;
            if (acc) m_cnt = m_cnt + 1'b1;
            nxt_ack = m_ack;
            for (int i = 0; i < NP; i++) if (m_ack[i] && !req_valid[i]) nxt_ack[i] = 1'b0;
            g = -1;
            if (arb_en && free) begin
                for (int k = 0; k < NP; k++) begin
                    idx = (m_rr + k) % NP;
                    if (g < 0 && req_valid[idx] && !m_ack[idx]) g = idx;
                end
            end
            if (g >= 0) begin
                r.data = req_data[g*DW +: DW];
                r.user = 8'(1 << g);
                exp_q.push_back(r);
                nxt_ack[g] = 1'b1;
                m_rr = (g + 1) % NP;
                m_valid = 1'b1;
            end else if (acc) begin
                m_valid = 1'b0;
            end
            m_ack = nxt_ack;
        end
    end

    // Monitor: compares every cycle at the falling edge and pops on each downstream accept.
    always @(negedge clk) begin
        log_t l;
        cyc++;
        check("req_ack", req_ack, m_ack);
        check("m_tvalid", m_tvalid, m_valid);
        check("m_tlast", m_tlast, m_valid);
        check("m_tstrb", m_tstrb, {(DW/8){m_valid}});
        check("record_count", record_count, m_cnt);
        if (!m_valid) check("m_tuser_idle", m_tuser, 8'h00);
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard: m_tvalid high with no expected record (cycle %0d)", cyc);
            end else begin
                check("m_tdata", m_tdata, exp_q[0].data);
                check("m_tuser", m_tuser, exp_q[0].user);
                if (m_tready) begin
                    l.data = m_tdata;
                    l.user = m_tuser;
                    l.stamp = cyc;
                    log_q.push_back(l);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #3;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NP; i++) if (ph[i] != 0) return 1'b0;
        return (force_req == '0) && (req_valid == '0) && (req_ack == '0) && !m_tvalid && (exp_q.size() == 0);
    endfunction

    task automatic wait_idle(input int bound, input string name);
        for (int c = 0; c < bound; c++) begin
            next();
            if (all_idle()) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: not idle after %0d cycles", name, bound);
    endtask

    task automatic check_log(input int idx, input logic [7:0] user, input string name);
        if (idx < log_q.size()) begin
            check(name, log_q[idx].user, user);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: only %0d records logged, needed index %0d", name, log_q.size(), idx);
        end
    endtask

    task automatic check_gap(input int idx, input string name);
        if (idx + 1 < log_q.size()) begin
            check(name, 256'(log_q[idx+1].stamp - log_q[idx].stamp), 256'(1));
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: only %0d records logged", name, log_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    initial begin
        int n01;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // Single port with a patterned record
        log_q.delete();
        hold_set[1] = 0;
        force_data[1] = {(DW/8){8'hA5}};
        force_req[1] = 1'b1;
        wait_idle(40, "t1_idle");
        check("t1_nrec", log_q.size(), 1);
        check_log(0, 8'h02, "t1_tuser");
        if (log_q.size() > 0) check("t1_tdata", log_q[0].data, {(DW/8){8'hA5}});
        check("t1_count", record_count, 1);

        // All ports at once from a fresh pointer
        pulse_reset();
        log_q.delete();
        for (int i = 0; i < NP; i++) begin
            hold_set[i] = 0;
            force_data[i] = rand_record();
        end
        force_req = '1;
        wait_idle(40, "t2_idle");
        check_log(0, 8'h01, "t2_user0");
        check_log(1, 8'h02, "t2_user1");
        check_log(2, 8'h04, "t2_user2");
        check_log(3, 8'h08, "t2_user3");
        for (int i = 0; i < 3; i++) check_gap(i, "t2_gap");
        check("t2_count", record_count, 4);

        // Fairness: after port 2 wins, port 3 precedes port 0
        force_data[2] = rand_record();
        force_req[2] = 1'b1;
        wait_idle(40, "t3a_idle");
        log_q.delete();
        force_data[0] = rand_record();
        force_data[3] = rand_record();
        force_req = 4'b1001;
        wait_idle(40, "t3b_idle");
        check_log(0, 8'h08, "t3_first");
        check_log(1, 8'h01, "t3_second");

        // Backpressure with ports 0 and 2 pending
        log_q.delete();
        m_tready = 1'b0;
        force_data[0] = rand_record();
        force_data[2] = rand_record();
        force_req = 4'b0101;
        repeat (3) next();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("t4_hold_user", m_tuser, 8'h04);
            check("t4_hold_valid", m_tvalid, 1);
            check("t4_no_ack0", req_ack[0], 0);
        end
        next();
        m_tready = 1'b1;
        wait_idle(40, "t4_idle");
        check_log(0, 8'h04, "t4_first");
        check_log(1, 8'h01, "t4_second");
        check_gap(0, "t4_gap");

        // Sticky valid: one record only
        log_q.delete();
        hold_set[0] = 10;
        force_data[0] = rand_record();
        force_req[0] = 1'b1;
        wait_idle(60, "t5a_idle");
        n01 = 0;
        foreach (log_q[i]) if (log_q[i].user == 8'h01) n01++;
        check("t5_sticky_count", n01, 1);

        // Arbitration disabled
        log_q.delete();
        arb_en = 1'b0;
        force_data[1] = rand_record();
        force_req[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("t5_dis_valid", m_tvalid, 0);
            check("t5_dis_ack", req_ack, 0);
        end
        next();
        arb_en = 1'b1;
        wait_idle(40, "t5b_idle");
        check_log(0, 8'h02, "t5_enable_grant");

        // Reset mid-record with acks 0101 held
        hold_set[0] = 40;
        force_data[0] = rand_record();
        force_req[0] = 1'b1;
        repeat (4) next();
        m_tready = 1'b0;
        hold_set[2] = 40;
        force_data[2] = rand_record();
        force_req[2] = 1'b1;
        repeat (4) next();
        @(negedge clk);
        #1;
        check("t6_pre_ack", req_ack, 4'b0101);
        check("t6_pre_valid", m_tvalid, 1);
        log_q.delete();
        reset = 1'b1;
        #1;
        check("t6_rst_ack", req_ack, 0);
        check("t6_rst_valid", m_tvalid, 0);
        check("t6_rst_last", m_tlast, 0);
        check("t6_rst_user", m_tuser, 0);
        check("t6_rst_strb", m_tstrb, 0);
        check("t6_rst_data", m_tdata, 0);
        check("t6_rst_count", record_count, 0);
        next();
        reset = 1'b0;
        m_tready = 1'b1;
        repeat (4) next();
        check_log(0, 8'h01, "t6_regrant_first");
        check_log(1, 8'h04, "t6_regrant_second");
        for (int i = 0; i < NP; i++) hold_set[i] = -1;
        wait_idle(200, "t6_idle");

        // Random traffic; the 8-bit record counter wraps along the way
        rand_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            next();
            m_tready = ($urandom_range(0, 3) != 0);
            arb_en = ($urandom_range(0, 9) != 0);
        end
        rand_en = 1'b0;
        m_tready = 1'b1;
        arb_en = 1'b1;
        wait_idle(300, "drain_idle");
        check("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
